// File: rtl/acc_offload_arbiter.sv
// Round-robin arbiter sharing one accelerator offload port among several requesters.
// Writeback requests are tracked in an in-order ID FIFO so responses return to their issuer.
module acc_offload_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumRs          = 3,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq*32-1:0]            q_instr_i,
  input  logic [NumReq*NumRs*DataWidth-1:0] q_rs_i,
  input  logic [NumReq-1:0]               q_wb_i,
  input  logic [NumReq-1:0]               q_valid_i,
  output logic [NumReq-1:0]               q_ready_o,
  output logic [DataWidth-1:0]            p_data_o,
  output logic [NumReq-1:0]               p_valid_o,
  input  logic [NumReq-1:0]               p_ready_i,
  output logic [31:0]                     acc_q_instr_o,
  output logic [NumRs*DataWidth-1:0]      acc_q_rs_o,
  output logic                            acc_q_wb_o,
  output logic                            acc_q_valid_o,
  input  logic                            acc_q_ready_i,
  input  logic [DataWidth-1:0]            acc_p_data_i,
  input  logic                            acc_p_valid_i,
  output logic                            acc_p_ready_o,
  output logic [CntW-1:0]                 outstanding_o,
  output logic                            err_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned RsW  = NumRs * DataWidth;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? PtrW'(0) : p + PtrW'(1);
  endfunction

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [IdxW-1:0] fifo_d [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] sel_s, cand_s, head_s;
  logic            found_s, sel_wb_s, blocked_s, fifo_full_s, fifo_empty_s;
  logic            q_hs_s, push_s, pop_s;

  assign fifo_full_s  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty_s = (cnt_q == CntW'(0));
  assign head_s       = fifo_q[rd_ptr_q];
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Grant selection: hold the locked index, otherwise search upward from rr_ptr+1.
  always_comb begin
    sel_s   = lock_idx_q;
    cand_s  = '0;
    found_s = 1'b0;
    if (lock_q) begin
      sel_s = lock_idx_q;
    end else begin
      for (int k = 1; k <= int'(NumReq); k++) begin
        cand_s = IdxW'((int'(rr_ptr_q) + k) % int'(NumReq));
        if (!found_s && q_valid_i[cand_s]) begin
          found_s = 1'b1;
          sel_s   = cand_s;
        end
      end
    end
  end

  // Request path: forward the selected requester; a full FIFO stalls writeback requests.
  always_comb begin
    sel_wb_s      = q_wb_i[sel_s];
    blocked_s     = sel_wb_s && fifo_full_s;
    acc_q_valid_o = (|q_valid_i) && !blocked_s;
    q_hs_s        = acc_q_valid_o && acc_q_ready_i;
    q_ready_o     = '0;
    if (q_hs_s) begin
      q_ready_o[sel_s] = 1'b1;
    end else begin
      q_ready_o = '0;
    end
    if (acc_q_valid_o) begin
      acc_q_instr_o = q_instr_i[int'(sel_s)*32 +: 32];
      acc_q_rs_o    = q_rs_i[int'(sel_s)*int'(RsW) +: RsW];
      acc_q_wb_o    = sel_wb_s;
    end else begin
      acc_q_instr_o = '0;
      acc_q_rs_o    = '0;
      acc_q_wb_o    = 1'b0;
    end
  end

  // Lock the grant while the downstream stalls; advance the pointer on handshake.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (q_hs_s) begin
      rr_ptr_d = sel_s;
      lock_d   = 1'b0;
    end else if (acc_q_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_s;
    end else begin
      lock_d = lock_q;
    end
  end

  // Response path: route to the FIFO head; with nothing outstanding, swallow and flag.
  always_comb begin
    p_valid_o     = '0;
    p_data_o      = '0;
    acc_p_ready_o = 1'b0;
    err_d         = err_q;
    if (!fifo_empty_s) begin
      p_valid_o[head_s] = acc_p_valid_i;
      p_data_o          = acc_p_valid_i ? acc_p_data_i : '0;
      acc_p_ready_o     = p_ready_i[head_s];
    end else begin
      acc_p_ready_o = acc_p_valid_i;
      if (acc_p_valid_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // ID FIFO bookkeeping; push is gated by start-of-cycle occupancy via blocked_s.
  always_comb begin
    push_s   = q_hs_s && sel_wb_s;
    pop_s    = !fifo_empty_s && acc_p_valid_i && acc_p_ready_o;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = sel_s;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= IdxW'(NumReq - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fifo_q     <= fifo_d;
    end
  end

  for (genvar g = 0; g < int'(NumReq); g++) begin : g_valid_hold
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (q_valid_i[g] && !q_ready_o[g]) |=> q_valid_i[g]);
  end

  a_lock_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> acc_q_valid_o);

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(MaxOutstanding));

endmodule
